// File: rtl/aes_pipe_sched.sv
`timescale 1ns/1ps
// aes_pipe_sched: sequences key load and N-block bursts into the pipelined AES core, with credit-based output backpressure.
// Optional O_run_cycles counter is built only when AES_SCHED_CYCLE_CNT_EN is defined.
module aes_pipe_sched #(
    parameter int pPT_WIDTH   = 128,
    parameter int pCNT_WIDTH  = 16,
    parameter int pFREE_WIDTH = 10
) (
    input  logic                   crypto_clk,
    input  logic                   reset_n,
    input  logic                   I_start,
    input  logic [pCNT_WIDTH-1:0]  I_burst_len,
    input  logic                   I_load_key,
    output logic                   O_core_key_load,
    input  logic                   I_core_key_ready,
    input  logic                   I_fifo_in_empty,
    input  logic [pPT_WIDTH-1:0]   I_fifo_in_data,
    output logic                   O_fifo_in_rd,
    output logic                   O_core_valid,
    output logic [pPT_WIDTH-1:0]   O_core_data,
    input  logic                   I_core_valid,
    input  logic [pPT_WIDTH-1:0]   I_core_data,
    input  logic [pFREE_WIDTH-1:0] I_fifo_out_free,
    output logic                   O_fifo_out_wr,
    output logic [pPT_WIDTH-1:0]   O_fifo_out_data,
    output logic                   O_busy,
    output logic                   O_trigger,
    output logic                   O_done,
    input  logic                   I_clear_errors,
    output logic [1:0]             O_errors,
    output logic [31:0]            O_run_cycles
);
    typedef enum logic [1:0] {IDLE, KEY, RUN, DRAIN} state_t;
    state_t state, state_nxt;

    logic [pCNT_WIDTH-1:0]  remaining;
    logic [pFREE_WIDTH-1:0] inflight;
    logic                   done_zero;
    logic                   key_cmd, start_ok, issue, retire_ok;
    logic                   err_orphan, err_cmd;
    logic                   vld_p1;
    logic [pPT_WIDTH-1:0]   data_p1;

    assign key_cmd    = (state == IDLE) && I_load_key;
    assign start_ok   = (state == IDLE) && I_start && !I_load_key;
    // Credit check: every issued block must already own a free output slot.
    assign issue      = (state == RUN) && !I_fifo_in_empty && (remaining != '0)
                        && (inflight < I_fifo_out_free);
    assign retire_ok  = I_core_valid && (inflight != '0);
    assign err_orphan = I_core_valid && (inflight == '0);
    assign err_cmd    = ((state != IDLE) && (I_start || I_load_key))
                        || ((state == IDLE) && I_start && I_load_key);

    always_ff @(posedge crypto_clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (key_cmd)
                    state_nxt = KEY;
                else if (start_ok && (I_burst_len != '0))
                    state_nxt = RUN;
            end
            KEY:     if (I_core_key_ready) state_nxt = IDLE;
            RUN:     if (issue && (remaining == pCNT_WIDTH'(1))) state_nxt = DRAIN;
            DRAIN:   if (inflight == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        O_core_key_load = key_cmd;
        O_fifo_in_rd    = issue;
        O_core_valid    = issue;
        O_busy          = (state != IDLE);
        O_trigger       = (inflight != '0) || issue;
        O_done          = done_zero || ((state == DRAIN) && (inflight == '0));
    end

    always_ff @(posedge crypto_clk or negedge reset_n) begin
        if (!reset_n) begin
            remaining <= '0;
            inflight  <= '0;
            done_zero <= 1'b0;
            O_errors  <= 2'b00;
        end else begin
            if (start_ok && (I_burst_len != '0))
                remaining <= I_burst_len;
            else if (issue)
                remaining <= remaining - pCNT_WIDTH'(1);

            case ({issue, vld_p1})
                2'b10:   inflight <= inflight + pFREE_WIDTH'(1);
                2'b01:   inflight <= inflight - pFREE_WIDTH'(1);
                default: inflight <= inflight;
            endcase

            done_zero <= start_ok && (I_burst_len == '0);
            O_errors  <= (I_clear_errors ? 2'b00 : O_errors) | {err_cmd, err_orphan};
        end
    end

    // Retire stage p1: core result registered into the ciphertext FIFO write port.
    always_ff @(posedge crypto_clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
        end else begin
            vld_p1 <= retire_ok;
            if (retire_ok)
                data_p1 <= I_core_data;
        end
    end

    assign O_core_data     = I_fifo_in_data;
    assign O_fifo_out_wr   = vld_p1;
    assign O_fifo_out_data = data_p1;

`ifdef AES_SCHED_CYCLE_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic [31:0] run_cycles;

    always_ff @(posedge crypto_clk or negedge reset_n) begin
        if (!reset_n)
            run_cycles <= '0;
        else if ((state != RUN) && (state_nxt == RUN))
            run_cycles <= '0;
        else if ((state == RUN) || (state == DRAIN))
            run_cycles <= sat_inc(run_cycles);
    end

    assign O_run_cycles = run_cycles;
`else
    assign O_run_cycles = 32'd0;
`endif

endmodule
